// File: rtl/pc_sequencer.sv
// Program-counter sequencer: conditional relative/absolute jumps, call/return
// through a small return-address stack, stall, and sticky stack error flags.
module pc_sequencer #(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 16,
    parameter int OFF_W       = 8,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_ADDR  = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               stall,
    input  logic [1:0]                         bc,
    input  logic [2:0]                         ps,
    input  logic [DATA_W-1:0]                  d,
    input  logic [DATA_W-1:0]                  a,
    input  logic [OFF_W-1:0]                   offset,
    output logic [ADDR_W-1:0]                  pc,
    output logic                               taken,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp_count,
    output logic                               overflow,
    output logic                               underflow
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    typedef enum logic [2:0] {
        PS_HOLD = 3'd0,
        PS_INC  = 3'd1,
        PS_REL  = 3'd2,
        PS_ABS  = 3'd3,
        PS_CALL = 3'd4,
        PS_RET  = 3'd5
    } ps_e;

    typedef enum logic [1:0] {
        BC_ZERO    = 2'd0,
        BC_NONZERO = 2'd1,
        BC_NEG     = 2'd2,
        BC_ALWAYS  = 2'd3
    } bc_e;

    logic [ADDR_W-1:0] stack [STACK_DEPTH];
    logic [ADDR_W-1:0] off_ext;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] top;
    logic [ADDR_W-1:0] pc_d;
    logic              taken_d;
    logic              ovf_d;
    logic              unf_d;
    logic              cond;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    // Offset is sign-extended when narrower than the PC, truncated otherwise.
    generate
        if (OFF_W >= ADDR_W) begin : g_off_trunc
            assign off_ext = offset[ADDR_W-1:0];
            if (OFF_W > ADDR_W) begin : g_off_unused
                logic unused_off;
                assign unused_off = &{1'b0, offset[OFF_W-1:ADDR_W]};
            end
        end else begin : g_off_sext
            assign off_ext = {{(ADDR_W-OFF_W){offset[OFF_W-1]}}, offset};
        end
        if (DATA_W > ADDR_W) begin : g_a_unused
            logic unused_a;
            assign unused_a = &{1'b0, a[DATA_W-1:ADDR_W]};
        end
    endgenerate

    assign pc_inc = pc + ADDR_W'(1);
    assign target = a[ADDR_W-1:0];
    assign full   = (sp_count == SP_W'(STACK_DEPTH));
    assign empty  = (sp_count == '0);

    always_comb begin
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_count == SP_W'(i + 1)) top = stack[i];
        end
    end

    always_comb begin
        cond = 1'b1;
        case (bc_e'(bc))
            BC_ZERO:    cond = (d == '0);
            BC_NONZERO: cond = (d != '0);
            BC_NEG:     cond = d[DATA_W-1];
            BC_ALWAYS:  cond = 1'b1;
            default:    cond = 1'b1;
        endcase
    end

    always_comb begin
        pc_d    = pc;
        taken_d = 1'b0;
        ovf_d   = overflow;
        unf_d   = underflow;
        push    = 1'b0;
        pop     = 1'b0;
        case (ps)
            PS_INC: pc_d = pc_inc;
            PS_REL: begin
                pc_d    = cond ? (pc_inc + off_ext) : pc_inc;
                taken_d = cond;
            end
            PS_ABS: begin
                pc_d    = cond ? target : pc_inc;
                taken_d = cond;
            end
            PS_CALL: begin
                if (!cond) begin
                    pc_d = pc_inc;
                end else if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    pc_d    = target;
                    taken_d = 1'b1;
                    push    = 1'b1;
                end
            end
            PS_RET: begin
                if (!cond) begin
                    pc_d = pc_inc;
                end else if (empty) begin
                    unf_d = 1'b1;
                end else begin
                    pc_d    = top;
                    taken_d = 1'b1;
                    pop     = 1'b1;
                end
            end
            default: pc_d = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= ADDR_W'(RESET_ADDR);
            taken     <= 1'b0;
            sp_count  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (!stall) begin
            pc        <= pc_d;
            taken     <= taken_d;
            overflow  <= ovf_d;
            underflow <= unf_d;
            if (push)     sp_count <= sp_count + SP_W'(1);
            else if (pop) sp_count <= sp_count - SP_W'(1);
        end
    end

    // Entries need no reset: sp_count alone defines which are valid.
    always_ff @(posedge clk) begin
        if (!reset && !stall && push) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (sp_count == SP_W'(i)) stack[i] <= pc_inc;
            end
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized checks of pc_sequencer against a queue-based PC/stack model.
module tb_pc_sequencer;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;
    localparam int OFF_W  = 8;
    localparam int DEPTH  = 4;
    localparam int MASK   = (1 << ADDR_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              stall = 1'b0;
    logic [1:0]        bc = '0;
    logic [2:0]        ps = '0;
    logic [DATA_W-1:0] d = '0;
    logic [DATA_W-1:0] a = '0;
    logic [OFF_W-1:0]  offset = '0;
    logic [ADDR_W-1:0] pc;
    logic              taken;
    logic [2:0]        sp_count;
    logic              overflow;
    logic              underflow;

    int tests = 0;
    int fails = 0;

    int m_pc = 0;
    int m_taken = 0;
    int m_ovf = 0;
    int m_unf = 0;
    int m_stack[$];

    pc_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OFF_W(OFF_W),
                   .STACK_DEPTH(DEPTH), .RESET_ADDR(0)) dut (
        .clk(clk), .reset(reset), .stall(stall), .bc(bc), .ps(ps), .d(d), .a(a),
        .offset(offset), .pc(pc), .taken(taken), .sp_count(sp_count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int expv);
        tests++;
        assert (act === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, expv);
        end
    endtask

    function automatic bit cond_of(input logic [1:0] b, input logic [DATA_W-1:0] v);
        case (b)
            2'd0: return v == 0;
            2'd1: return v != 0;
            2'd2: return v[DATA_W-1];
            default: return 1'b1;
        endcase
    endfunction

    // Reference: spec rules applied to integers and a queue stack.
    task automatic model_step();
        int nxt;
        int off;
        bit c;
        if (reset) begin
            m_pc = 0; m_taken = 0; m_ovf = 0; m_unf = 0;
            m_stack.delete();
            return;
        end
        if (stall) return;
        nxt = (m_pc + 1) & MASK;
        off = int'($signed(offset));
        c = cond_of(bc, d);
        m_taken = 0;
        case (ps)
            3'd1: m_pc = nxt;
            3'd2: if (c) begin m_pc = (m_pc + off + 1) & MASK; m_taken = 1; end
                  else m_pc = nxt;
            3'd3: if (c) begin m_pc = int'(a) & MASK; m_taken = 1; end
                  else m_pc = nxt;
            3'd4: if (!c) m_pc = nxt;
                  else if (m_stack.size() == DEPTH) m_ovf = 1;
                  else begin m_stack.push_back(nxt); m_pc = int'(a) & MASK; m_taken = 1; end
            3'd5: if (!c) m_pc = nxt;
                  else if (m_stack.size() == 0) m_unf = 1;
                  else begin m_pc = m_stack.pop_back(); m_taken = 1; end
            default: ;
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, int'(pc), m_pc);
        chk({tag, ".taken"}, int'(taken), m_taken);
        chk({tag, ".sp"}, int'(sp_count), m_stack.size());
        chk({tag, ".ovf"}, int'(overflow), m_ovf);
        chk({tag, ".unf"}, int'(underflow), m_unf);
    endtask

    task automatic cyc(input string tag, input logic r, input logic s, input logic [2:0] p,
                       input logic [1:0] b, input logic [DATA_W-1:0] dv,
                       input logic [DATA_W-1:0] av, input logic [OFF_W-1:0] ov);
        @(negedge clk);
        reset = r; stall = s; ps = p; bc = b; d = dv; a = av; offset = ov;
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        int r;
        cyc("reset", 1, 0, 0, 0, 0, 0, 0);
        chk("reset_pc", int'(pc), 0);

        for (int i = 0; i < 70; i++) begin
            cyc("inc", 0, 0, 1, 0, 0, 0, 0);
            if (i == 63) chk("wrap_pc", int'(pc), 0);
        end

        cyc("abs10", 0, 0, 3, 3, 0, 10, 0);
        cyc("rel_neg", 0, 0, 2, 3, 0, 0, 8'hFB);
        chk("rel_neg_pc", int'(pc), 6);
        cyc("rel_untaken", 0, 0, 2, 0, 16'h0001, 0, 8'hFB);
        chk("rel_untaken_pc", int'(pc), 7);

        cyc("neg_taken", 0, 0, 3, 2, 16'h8000, 16'h0025, 0);
        chk("neg_taken_pc", int'(pc), 37);
        cyc("neg_untaken", 0, 0, 3, 2, 16'h7FFF, 16'h0025, 0);
        chk("neg_untaken_pc", int'(pc), 38);

        cyc("abs3", 0, 0, 3, 3, 0, 3, 0);
        cyc("call20", 0, 0, 4, 3, 0, 20, 0);
        chk("call20_sp", int'(sp_count), 1);
        cyc("call40", 0, 0, 4, 3, 0, 40, 0);
        chk("call40_pc", int'(pc), 40);
        cyc("ret1", 0, 0, 5, 3, 0, 0, 0);
        chk("ret1_pc", int'(pc), 21);
        cyc("ret2", 0, 0, 5, 3, 0, 0, 0);
        chk("ret2_pc", int'(pc), 4);
        chk("ret2_sp", int'(sp_count), 0);

        for (int i = 0; i < 4; i++) cyc("fill", 0, 0, 4, 3, 0, DATA_W'(10 + i), 0);
        chk("full_sp", int'(sp_count), 4);
        cyc("overflow", 0, 0, 4, 3, 0, 50, 0);
        chk("overflow_pc", int'(pc), 13);
        chk("overflow_flag", int'(overflow), 1);
        cyc("ovf_sticky", 0, 0, 1, 0, 0, 0, 0);
        chk("ovf_sticky_flag", int'(overflow), 1);
        cyc("reset_mid", 1, 0, 0, 0, 0, 0, 0);
        chk("reset_mid_sp", int'(sp_count), 0);
        cyc("underflow", 0, 0, 5, 3, 0, 0, 0);
        chk("underflow_pc", int'(pc), 0);
        chk("underflow_flag", int'(underflow), 1);

        cyc("abs9", 0, 0, 3, 3, 0, 9, 0);
        cyc("call_pre", 0, 0, 4, 3, 0, 30, 0);
        for (int i = 0; i < 3; i++) begin
            cyc("stall_call", 0, 1, 4, 3, 0, 55, 0);
            chk("stall_pc", int'(pc), 30);
            chk("stall_sp", int'(sp_count), 1);
            chk("stall_taken", int'(taken), 1);
        end
        cyc("reset_stall", 1, 1, 4, 3, 0, 55, 0);
        chk("reset_stall_pc", int'(pc), 0);
        chk("reset_stall_sp", int'(sp_count), 0);

        for (int i = 0; i < 500; i++) begin
            logic [DATA_W-1:0] dv;
            r = int'($urandom_range(0, 3));
            dv = (r == 0) ? '0 : (r == 1) ? (DATA_W'($urandom) | 16'h8000) : DATA_W'($urandom);
            cyc("rand", ($urandom_range(0, 99) < 2), ($urandom_range(0, 9) == 0),
                3'($urandom_range(0, 7)), 2'($urandom), dv, DATA_W'($urandom),
                OFF_W'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the single-cycle RISC core; the next generation of the core's PC block. It adds a full branch-condition set including negative, fall-through on untaken branches, CALL/RETURN through an internal return-address stack, a stall input and sticky stack error flags. Sits between the control decoder (bc, ps, offset) and the instruction memory address port; the register file supplies d and a.

Parameters:
ADDR_W, 6, width of instruction address / PC
DATA_W, 16, width of register operands d and a
OFF_W, 8, width of signed relative-jump offset (must be less than or equal to DATA_W)
STACK_DEPTH, 4, number of return-address stack entries (at least 1)
RESET_ADDR, 0, PC value loaded on reset

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
stall  in  1  1 = freeze all state this cycle
bc  in  2  branch condition: 0 zero, 1 nonzero, 2 negative, 3 always
ps  in  3  PC update style: 0 hold, 1 inc, 2 rel, 3 abs, 4 call, 5 ret, 6/7 reserved
d  in  DATA_W  tested register value
a  in  DATA_W  absolute target source (low ADDR_W bits used)
offset  in  OFF_W  signed two's-complement relative offset
pc  out  ADDR_W  current instruction address (registered)
taken  out  1  registered; 1 if the last non-stalled update was a taken rel/abs/call/ret
sp_count  out  clog2(STACK_DEPTH+1)  number of valid stack entries
overflow  out  1  sticky: call attempted with stack full
underflow  out  1  sticky: ret attempted with stack empty

Behaviour:
- Reset (clk edge with reset=1, overrides stall): pc=RESET_ADDR, taken=0, sp_count=0, overflow=0, underflow=0; stack contents don't-care.
- Reset asserted mid-sequence (stack partly full) discards all stack entries in one cycle.
- stall=1 and reset=0: pc, taken, sp_count, stack and flags all hold; inputs ignored.
- Condition cond: bc=0 -> d==0; bc=1 -> d!=0; bc=2 -> d[DATA_W-1]==1; bc=3 -> 1.
- pc_next = pc+1, modulo 2^ADDR_W. All PC arithmetic wraps modulo 2^ADDR_W, with no error.
- ps=0 hold: pc unchanged; taken=0.
- ps=1 inc: pc=pc_next unconditionally (bc ignored); taken=0.
- ps=2 rel: if cond, pc = pc + sext(offset) + 1, computed at ADDR_W width with offset sign-extended or truncated; taken=1. Else pc=pc_next; taken=0.
- ps=3 abs: if cond, pc=a[ADDR_W-1:0]; taken=1. Else pc=pc_next; taken=0.
- ps=4 call, cond true, stack not full: push pc_next; sp_count+1; pc=a[ADDR_W-1:0]; taken=1.
- ps=4 call, cond true, stack full (sp_count==STACK_DEPTH): no push, pc holds, overflow=1, taken=0.
- ps=4 call, cond false: pc=pc_next, no push, taken=0.
- ps=5 ret, cond true, stack non-empty: pc=top entry; pop; sp_count-1; taken=1.
- ps=5 ret, cond true, stack empty: pc holds, underflow=1, taken=0.
- ps=5 ret, cond false: pc=pc_next, no pop, taken=0.
- ps=6/7: treated as hold; taken=0.
- Latency: every update is visible on pc the cycle after the deciding edge; no combinational path from inputs to outputs.
- overflow and underflow are cleared only by reset.
- Stack is LIFO, implemented as a register array with a pointer; a push and a pop never occur in the same cycle.

Test Plan:
- Reset, then ps=1 for 70 cycles -> pc counts 0..63, wraps to 0 at cycle 64; taken=0 throughout.
- pc=10; ps=2, bc=3, offset=8'hFB (-5) -> pc=6, taken=1. Then ps=2, bc=0, d=16'h0001 -> pc=7, taken=0.
- bc=2: d=16'h8000 with ps=3, a=16'h0025 -> pc=37; then d=16'h7FFF with ps=3 -> pc=38.
- From pc=3, call a=20 -> pc=20, sp_count=1. Call a=40 -> pc=40, sp_count=2. Ret -> pc=21. Ret -> pc=4, sp_count=0.
- 4 calls fill the stack (sp_count=4); a 5th call -> pc holds, overflow=1. Reset -> sp_count=0, flags 0. Ret on empty -> pc holds, underflow=1.
- stall=1 for 3 cycles during ps=4 call -> pc, sp_count, taken unchanged. Reset with stall=1 -> pc=RESET_ADDR.
